// File: rtl/noc_pkt_gen.sv
// noc_pkt_gen: per-node packet injector driving the mesh NoC router local port.
// Define NOC_PKT_GEN_RETX_EN to add resend support (retx_req / retx_cnt and a shadow of the last packet).
module noc_pkt_gen #(
    parameter int NODE_NUM = 9,
    parameter int SRC_ID   = 0,
    parameter int ID_W     = 4,
    parameter int TIME_W   = 10,
    parameter int DATA_W   = 20,
    parameter int SEQ_LEN  = 9,
    parameter int CNT_W    = 4,
    parameter int RATE_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [CNT_W-1:0]          send_num,
    input  logic [RATE_W-1:0]         rate,
    input  logic [1:0]                mode,
    input  logic [SEQ_LEN*ID_W-1:0]   dst_seq,
    input  logic [TIME_W-1:0]         now_time,
    input  logic                      pkt_ready,
`ifdef NOC_PKT_GEN_RETX_EN
    input  logic                      retx_req,
    output logic [CNT_W-1:0]          retx_cnt,
`endif
    output logic                      pkt_valid,
    output logic [2*ID_W+TIME_W+DATA_W+1:0] pkt_data,
    output logic [CNT_W-1:0]          send_cnt,
    output logic                      task_send_finish_flag,
    output logic                      cfg_err
);

    localparam int PKT_W = 2*ID_W + TIME_W + DATA_W + 2;
    localparam int PTR_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_SEND, S_GAP, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        send_num_q;
    logic [RATE_W-1:0]       rate_q, gap_q;
    logic [1:0]              mode_q;
    logic [SEQ_LEN*ID_W-1:0] seq_q;
    logic [PTR_W-1:0]        ptr_q, rej_q, ptr_nxt;
    logic [15:0]             lfsr_q;
    logic                    lfsr_fb;
    logic [ID_W-1:0]         seq_arr [SEQ_LEN];
    logic [ID_W-1:0]         cand;
    logic                    rnd_mode, seq_mode, cand_legal, cfg_fail, last_pkt;
    logic                    retx_take, cur_retx;

`ifdef NOC_PKT_GEN_RETX_EN
    logic                    retx_pend_q, cur_retx_q, shadow_v_q;
    logic [ID_W-1:0]         shadow_dst_q;
    logic [DATA_W-1:0]       shadow_data_q;
    assign retx_take = retx_pend_q;
    assign cur_retx  = cur_retx_q;
`else
    assign retx_take = 1'b0;
    assign cur_retx  = 1'b0;
`endif

    // Entry 0 of the destination list sits at the MSBs.
    always_comb begin
        for (int i = 0; i < SEQ_LEN; i++) begin
            seq_arr[i] = seq_q[(SEQ_LEN-1-i)*ID_W +: ID_W];
        end
    end

    always_comb begin
        rnd_mode = (mode_q == 2'b10);
        seq_mode = (mode_q == 2'b00) || (mode_q == 2'b11);
        if (rnd_mode)      cand = lfsr_q[ID_W-1:0];
        else if (seq_mode) cand = seq_arr[ptr_q];
        else               cand = seq_arr[0];
        cand_legal = (int'(cand) < NODE_NUM) && (int'(cand) != SRC_ID);
        cfg_fail   = !rnd_mode && (rej_q == PTR_W'(SEQ_LEN-1));
        ptr_nxt    = (ptr_q == PTR_W'(SEQ_LEN-1)) ? '0 : ptr_q + PTR_W'(1);
        last_pkt   = !cur_retx && ((send_cnt + CNT_W'(1)) == send_num_q);
        lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (enable) state_d = (send_num != '0) ? S_PICK : S_DONE;
                S_PICK: if (enable) begin
                    if (retx_take || cand_legal) state_d = S_SEND;
                    else if (cfg_fail)           state_d = S_DONE;
                end
                S_SEND: if (pkt_ready) begin
                    if (last_pkt)            state_d = S_DONE;
                    else if (rate_q == '0)   state_d = S_PICK;
                    else                     state_d = S_GAP;
                end
                S_GAP:  if (gap_q <= RATE_W'(1)) state_d = S_PICK;
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_valid             = (state_q == S_SEND);
        task_send_finish_flag = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_num_q <= '0;
            rate_q     <= '0;
            gap_q      <= '0;
            mode_q     <= '0;
            seq_q      <= '0;
            ptr_q      <= '0;
            rej_q      <= '0;
            lfsr_q     <= 16'hACE1;
            pkt_data   <= '0;
            send_cnt   <= '0;
            cfg_err    <= 1'b0;
`ifdef NOC_PKT_GEN_RETX_EN
            retx_pend_q   <= 1'b0;
            cur_retx_q    <= 1'b0;
            shadow_v_q    <= 1'b0;
            shadow_dst_q  <= '0;
            shadow_data_q <= '0;
            retx_cnt      <= '0;
`endif
        end else begin
            // The LFSR free-runs and survives flush so successive tasks see fresh destinations.
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
            if (flush) begin
                send_cnt <= '0;
                ptr_q    <= '0;
                rej_q    <= '0;
                cfg_err  <= 1'b0;
`ifdef NOC_PKT_GEN_RETX_EN
                retx_pend_q <= 1'b0;
                cur_retx_q  <= 1'b0;
                shadow_v_q  <= 1'b0;
                retx_cnt    <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: if (enable && send_num != '0) begin
                        send_num_q <= send_num;
                        rate_q     <= rate;
                        mode_q     <= mode;
                        seq_q      <= dst_seq;
                        send_cnt   <= '0;
                        rej_q      <= '0;
                    end
                    S_PICK: if (enable) begin
                        if (retx_take) begin
`ifdef NOC_PKT_GEN_RETX_EN
                            pkt_data    <= {ID_W'(SRC_ID), shadow_dst_q, now_time, shadow_data_q, 2'b10};
                            cur_retx_q  <= 1'b1;
                            retx_pend_q <= 1'b0;
`endif
                        end else if (cand_legal) begin
                            pkt_data <= {ID_W'(SRC_ID), cand, now_time, DATA_W'(send_cnt), 2'b01};
                            rej_q    <= '0;
                            if (seq_mode) ptr_q <= ptr_nxt;
`ifdef NOC_PKT_GEN_RETX_EN
                            cur_retx_q <= 1'b0;
`endif
                        end else begin
                            if (seq_mode)  ptr_q <= ptr_nxt;
                            if (!rnd_mode) rej_q <= rej_q + PTR_W'(1);
                            if (cfg_fail)  cfg_err <= 1'b1;
                        end
                    end
                    S_SEND: if (pkt_ready) begin
                        gap_q <= rate_q;
                        if (!cur_retx) send_cnt <= send_cnt + CNT_W'(1);
`ifdef NOC_PKT_GEN_RETX_EN
                        if (cur_retx_q) begin
                            retx_cnt <= retx_cnt + CNT_W'(1);
                        end else begin
                            shadow_v_q    <= 1'b1;
                            shadow_dst_q  <= pkt_data[PKT_W-ID_W-1 -: ID_W];
                            shadow_data_q <= pkt_data[2 +: DATA_W];
                        end
`endif
                    end
                    S_GAP:   gap_q <= gap_q - RATE_W'(1);
                    default: ;
                endcase
`ifdef NOC_PKT_GEN_RETX_EN
                // A request only counts once a packet exists to repeat; repeats collapse into one flag.
                if (retx_req && state_q != S_DONE && shadow_v_q) retx_pend_q <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_noc_pkt_gen.sv
// tb_noc_pkt_gen: randomized self-checking bench for noc_pkt_gen against a list-walking reference model.
// Resend scenarios are compiled in when NOC_PKT_GEN_RETX_EN is defined.
module tb_noc_pkt_gen;

    localparam int NODE_NUM = 9;
    localparam int SRC      = 4;
    localparam int ID_W     = 4;
    localparam int TIME_W   = 10;
    localparam int DATA_W   = 20;
    localparam int SEQ_LEN  = 9;
    localparam int CNT_W    = 4;
    localparam int RATE_W   = 4;
    localparam int PKT_W    = 2*ID_W + TIME_W + DATA_W + 2;
    localparam int EXP_W    = 1 + 8 + PKT_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    enable = 1'b0;
    logic                    flush = 1'b0;
    logic                    pkt_ready = 1'b0;
    logic [CNT_W-1:0]        send_num = '0;
    logic [RATE_W-1:0]       rate = '0;
    logic [1:0]              mode = '0;
    logic [SEQ_LEN*ID_W-1:0] dst_seq = '0;
    logic [TIME_W-1:0]       now_time = '0;
    logic                    pkt_valid;
    logic [PKT_W-1:0]        pkt_data;
    logic [CNT_W-1:0]        send_cnt;
    logic                    task_send_finish_flag;
    logic                    cfg_err;
`ifdef NOC_PKT_GEN_RETX_EN
    logic                    retx_req = 1'b0;
    logic [CNT_W-1:0]        retx_cnt;
    int                      exp_retx = 0;
`endif

    noc_pkt_gen #(
        .NODE_NUM(NODE_NUM), .SRC_ID(SRC), .ID_W(ID_W), .TIME_W(TIME_W),
        .DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .CNT_W(CNT_W), .RATE_W(RATE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .send_num(send_num), .rate(rate), .mode(mode), .dst_seq(dst_seq),
        .now_time(now_time), .pkt_ready(pkt_ready),
`ifdef NOC_PKT_GEN_RETX_EN
        .retx_req(retx_req), .retx_cnt(retx_cnt),
`endif
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .send_cnt(send_cnt),
        .task_send_finish_flag(task_send_finish_flag), .cfg_err(cfg_err)
    );

    // Clock and global time base
    always #5 clk = ~clk;
    always @(posedge clk) now_time <= now_time + 1'b1;

    // Scoreboard state: each entry is {random_dst, gap_to_first_valid, packet with time zeroed}
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ref_cyc = 0;
    int start_cyc = 0;
    int last_hs_cyc = 0;
    int done_at = 0;
    int hs_count = 0;
    int ready_mode = 0;
    int stall_left = 0;
    logic p_valid = 1'b0;
    logic p_ready = 1'b0;
    logic p_flush = 1'b0;
    logic [PKT_W-1:0] p_data = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [ID_W-1:0] f_src(input logic [PKT_W-1:0] p);
        return p[PKT_W-1 -: ID_W];
    endfunction
    function automatic logic [ID_W-1:0] f_dst(input logic [PKT_W-1:0] p);
        return p[PKT_W-ID_W-1 -: ID_W];
    endfunction
    function automatic logic [TIME_W-1:0] f_time(input logic [PKT_W-1:0] p);
        return p[DATA_W+2 +: TIME_W];
    endfunction
    function automatic logic [DATA_W-1:0] f_data(input logic [PKT_W-1:0] p);
        return p[2 +: DATA_W];
    endfunction
    function automatic bit legal(input int d);
        return (d < NODE_NUM) && (d != SRC);
    endfunction
    function automatic logic [EXP_W-1:0] make_exp(input bit rnd, input int gap, input int dst,
                                                  input int data, input logic [1:0] typ);
        return {rnd, 8'(gap), ID_W'(SRC), ID_W'(dst), {TIME_W{1'b0}}, DATA_W'(data), typ};
    endfunction

    task automatic handle_hs(input logic [PKT_W-1:0] d);
        logic [EXP_W-1:0] e;
        check_eq("hs_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("src", f_src(d), SRC);
            if (e[EXP_W-1]) check_eq("rnd_dst_legal", legal(int'(f_dst(d))), 1);
            else            check_eq("dst", f_dst(d), f_dst(e[PKT_W-1:0]));
            check_eq("data", f_data(d), f_data(e[PKT_W-1:0]));
            check_eq("type", d[1:0], e[1:0]);
        end
        last_hs_cyc = cyc - 1;
        ref_cyc     = cyc - 1;
        hs_count++;
    endtask

    // One clock: resolve the handshake of the edge just passed, check the new output, drive ready.
    task automatic tick();
        logic hs;
        logic [TIME_W-1:0] t_exp;
        p_flush = flush;
        @(negedge clk);
        cyc++;
        hs = p_valid && p_ready && !p_flush;
        if (hs) handle_hs(p_data);
        if (pkt_valid) begin
            if (p_valid && !hs && !p_flush) begin
                check_eq("stable", pkt_data, p_data);
            end else begin
                t_exp = now_time - 1'b1;
                check_eq("valid_expected", exp_q.size() != 0, 1);
                check_eq("time", f_time(pkt_data), t_exp);
                if (exp_q.size() != 0 && !exp_q[0][EXP_W-1])
                    check_eq("gap", cyc - ref_cyc, exp_q[0][PKT_W +: 8]);
            end
        end
        if (stall_left > 0 && pkt_valid) begin
            pkt_ready = 1'b0;
            stall_left--;
        end else begin
            pkt_ready = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        p_valid = pkt_valid;
        p_data  = pkt_data;
        p_ready = pkt_ready;
    endtask

    // Reference model: walk the destination list skipping illegal entries.
    task automatic build_model(input logic [1:0] md, input int n, input int rt,
                               input logic [SEQ_LEN*ID_W-1:0] seq, output bit err);
        int ent[SEQ_LEN];
        int p;
        int skips;
        bit any;
        err = 0;
        p = 0;
        any = 0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            ent[i] = int'(seq[(SEQ_LEN-1-i)*ID_W +: ID_W]);
            any |= legal(ent[i]);
        end
        if (n == 0) return;
        if (md == 2'b10) begin
            for (int k = 0; k < n; k++) exp_q.push_back(make_exp(1, 0, 0, k, 2'b01));
        end else if (md == 2'b01) begin
            if (!legal(ent[0])) err = 1;
            else for (int k = 0; k < n; k++)
                exp_q.push_back(make_exp(0, (k == 0) ? 2 : rt + 2, ent[0], k, 2'b01));
        end else if (!any) begin
            err = 1;
        end else begin
            for (int k = 0; k < n; k++) begin
                skips = 0;
                while (!legal(ent[p])) begin
                    skips++;
                    p = (p + 1) % SEQ_LEN;
                end
                exp_q.push_back(make_exp(0, ((k == 0) ? 2 : rt + 2) + skips, ent[p], k, 2'b01));
                p = (p + 1) % SEQ_LEN;
            end
        end
    endtask

    task automatic start_task(input logic [1:0] md, input int n, input int rt,
                              input logic [SEQ_LEN*ID_W-1:0] seq);
        mode      = md;
        send_num  = CNT_W'(n);
        rate      = RATE_W'(rt);
        dst_seq   = seq;
        enable    = 1'b1;
        start_cyc = cyc;
        ref_cyc   = cyc;
    endtask

    task automatic finish_task(input int n, input bit err);
        bit got = 0;
        for (int i = 0; i < 1000; i++) begin
            if (task_send_finish_flag) begin
                got = 1;
                break;
            end
            tick();
        end
        done_at = cyc;
        check_eq("done_seen", got, 1);
        if (err)         check_eq("cfg_done_cyc", cyc - start_cyc, 1 + SEQ_LEN);
        else if (n == 0) check_eq("zero_done_cyc", cyc - start_cyc, 1);
        else             check_eq("done_cyc", cyc, last_hs_cyc + 1);
        check_eq("cfg_err", cfg_err, err);
        check_eq("send_cnt", send_cnt, err ? 0 : n);
        check_eq("valid_in_done", pkt_valid, 0);
        check_eq("queue_empty", exp_q.size(), 0);
`ifdef NOC_PKT_GEN_RETX_EN
        check_eq("retx_cnt", retx_cnt, exp_retx);
`endif
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check_eq("done_hold", task_send_finish_flag, 1);
        flush  = 1'b1;
        enable = 1'b0;
        tick();
        flush = 1'b0;
        tick();
        check_eq("flush_flag", task_send_finish_flag, 0);
        check_eq("flush_cnt", send_cnt, 0);
        check_eq("flush_err", cfg_err, 0);
        exp_q.delete();
    endtask

    task automatic run_task(input logic [1:0] md, input int n, input int rt,
                            input logic [SEQ_LEN*ID_W-1:0] seq);
        bit err;
        build_model(md, n, rt, seq, err);
        start_task(md, n, rt, seq);
        finish_task(err ? 0 : n, err);
    endtask

    initial begin
        int h0;
        logic [SEQ_LEN*ID_W-1:0] rs;
        // Reset
        repeat (3) tick();
        check_eq("rst_valid", pkt_valid, 0);
        check_eq("rst_data", pkt_data, 0);
        check_eq("rst_cnt", send_cnt, 0);
        check_eq("rst_flag", task_send_finish_flag, 0);
        check_eq("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        tick();

        // Sequence mode, back-to-back: destinations 0,5,2, flag seven cycles after enable
        ready_mode = 0;
        run_task(2'b00, 3, 0, 36'h052349781);
        check_eq("t1_done_cycle", done_at - start_cyc, 7);

        // Gap of three idle cycles
        run_task(2'b00, 2, 3, 36'h052349781);

        // Back-pressure for five cycles
        stall_left = 5;
        run_task(2'b01, 2, 1, 36'h312345678);
        check_eq("stall_consumed", stall_left, 0);

        // No legal destination in the list
        run_task(2'b00, 5, 0, 36'hFFFFFFFFF);
        run_task(2'b11, 5, 0, 36'hF4F4F4F4F);
        run_task(2'b01, 5, 0, 36'h401234567);

        // Zero packets requested
        run_task(2'b00, 0, 0, 36'h012345678);

        // Uniform random destinations, randomized ready
        ready_mode = 1;
        run_task(2'b10, 15, 0, '0);

        // Randomized tasks across all modes
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < SEQ_LEN; i++) rs[i*ID_W +: ID_W] = ID_W'($urandom_range(0, 15));
            ready_mode = $urandom_range(0, 1);
            run_task(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 3), rs);
        end

        // Flush while a packet is pending
        ready_mode = 1;
        h0 = hs_count;
        build_model(2'b10, 15, 1, '0, rs[0]);
        start_task(2'b10, 15, 1, '0);
        for (int i = 0; i < 400 && !(hs_count >= h0 + 3 && pkt_valid); i++) tick();
        check_eq("flush_mid_reach", pkt_valid, 1);
        flush  = 1'b1;
        enable = 1'b0;
        tick();
        check_eq("flush_mid_valid", pkt_valid, 0);
        check_eq("flush_mid_cnt", send_cnt, 0);
        flush = 1'b0;
        exp_q.delete();
        tick();
        check_eq("flush_mid_idle", task_send_finish_flag, 0);

`ifdef NOC_PKT_GEN_RETX_EN
        // Resend request after the first accepted packet
        ready_mode = 0;
        h0 = hs_count;
        exp_q.push_back(make_exp(0, 2, 0, 0, 2'b01));
        exp_q.push_back(make_exp(0, 4, 0, 0, 2'b10));
        exp_q.push_back(make_exp(0, 4, 5, 1, 2'b01));
        exp_q.push_back(make_exp(0, 4, 2, 2, 2'b01));
        start_task(2'b00, 3, 2, 36'h052349781);
        for (int i = 0; i < 100 && hs_count < h0 + 1; i++) tick();
        retx_req = 1'b1;
        tick();
        retx_req = 1'b0;
        exp_retx = 1;
        finish_task(3, 0);
        exp_retx = 0;
`endif

        // Asynchronous reset while a packet is pending
        ready_mode = 0;
        stall_left = 4;
        build_model(2'b00, 3, 0, 36'h012345678, rs[0]);
        start_task(2'b00, 3, 0, 36'h012345678);
        for (int i = 0; i < 20 && !pkt_valid; i++) tick();
        check_eq("rst_mid_reach", pkt_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", pkt_valid, 0);
        check_eq("rst_mid_cnt", send_cnt, 0);
        p_valid    = 1'b0;
        stall_left = 0;
        enable     = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_mid_idle", task_send_finish_flag, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
